hazard_ctrl_gen: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS datapath. It replaces the single-bubble load-use detector with a sequential controller that provides:
- configurable multi-cycle load-use stall
- register-0 exclusion
- taken-branch flush
- full-pipeline freeze while a variable-latency data memory is busy
- a saturating stall-cycle counter for performance measurement.
It sits between the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.

---
 rtl/hazard_ctrl_gen.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_gen.sv
// Pipeline hazard controller for the 5-stage MIPS datapath: multi-cycle load-use
// stall, taken-branch flush, data-memory freeze and a saturating stall counter.
module hazard_ctrl_gen #(
    parameter int REG_ADDR_W = 5,
    parameter int LU_STALL   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    localparam logic [1:0] LU_INIT = 2'(LU_STALL - 1);

    state_t           state_reg, state_next;
    state_t           ret_reg, ret_next;
    state_t           eff_state;
    logic [1:0]       lu_cnt_reg, lu_cnt_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic             lu_hit;
    logic             mem_wait;

    assign lu_hit = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign mem_wait = dmem_req && !dmem_ready;

    // Once a freeze ends, the cycle behaves as the interrupted state would have.
    assign eff_state = (state_reg == ST_MEM_WAIT) ? ret_reg : state_reg;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        state_next   = state_reg;
        ret_next     = ret_reg;
        lu_cnt_next  = lu_cnt_reg;

        if (mem_wait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            state_next   = ST_MEM_WAIT;
            if (state_reg != ST_MEM_WAIT) begin
                ret_next = (state_reg == ST_LU_STALL) ? ST_LU_STALL : ST_IDLE;
            end
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_next   = ST_IDLE;
            lu_cnt_next  = 2'd0;
        end else begin
            case (eff_state)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                    if (lu_hit) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LU_STALL > 1) begin
                            state_next  = ST_LU_STALL;
                            lu_cnt_next = LU_INIT;
                        end
                    end
                end
                ST_LU_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    lu_cnt_next  = lu_cnt_reg - 2'd1;
                    state_next   = (lu_cnt_reg == 2'd1) ? ST_IDLE : ST_LU_STALL;
                end
                default: begin
                    state_next  = ST_IDLE;
                    lu_cnt_next = 2'd0;
                end
            endcase
        end

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            ret_reg         <= ST_IDLE;
            lu_cnt_reg      <= 2'd0;
            stall_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ret_reg    <= ret_next;
            lu_cnt_reg <= lu_cnt_next;
            if (!pc_write && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Scoreboard bench: two controller instances (LU_STALL=1 and 3, narrow counters)
// share one stimulus stream and are checked against a bubble-debt reference model.
module tb_hazard_ctrl_gen;

    localparam int CW0 = 6;
    localparam int CW1 = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
    logic       if_id_uses_rt, ex_branch_taken, dmem_req, dmem_ready;

    logic           pcw0, ifw0, fl0, idw0, bub0, exw0, busy0;
    logic           pcw1, ifw1, fl1, idw1, bub1, exw1, busy1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    always #5 clk = ~clk;

    hazard_ctrl_gen #(.REG_ADDR_W(5), .LU_STALL(1), .CNT_W(CW0)) dut0 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pcw0), .if_id_write(ifw0), .if_id_flush(fl0), .id_ex_write(idw0),
        .id_ex_bubble(bub0), .ex_mem_write(exw0), .busy(busy0), .stall_count(cnt0)
    );

    hazard_ctrl_gen #(.REG_ADDR_W(5), .LU_STALL(3), .CNT_W(CW1)) dut1 (
        .clk(clk), .reset(reset), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(fl1), .id_ex_write(idw1),
        .id_ex_bubble(bub1), .ex_mem_write(exw1), .busy(busy1), .stall_count(cnt1)
    );

    // ctl bit order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, busy
    typedef struct packed {
        logic [15:0] seq;
        logic [6:0]  ctl0;
        logic [6:0]  ctl1;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   seq_n = 0;

    // Reference model: outstanding bubble debt, whether last cycle was frozen, counter.
    int rem[2];
    bit pmw[2];
    int cnt[2];
    int lu_n[2];
    int cmax[2];

    task automatic step_model(input int k, input bit hit, input bit mw, input bit br,
                              input bit rst, output logic [6:0] ctl, output logic [15:0] c);
        bit busy_e, pcw, ifw, fl, idw, bub, exw;
        busy_e = pmw[k] || (rem[k] > 0);
        c = 16'(cnt[k]);
        pcw = 1; ifw = 1; fl = 0; idw = 1; bub = 0; exw = 1;
        if (rst) begin
            pcw = 0; ifw = 0; bub = 1;
            rem[k] = 0; pmw[k] = 0; cnt[k] = 0;
        end else begin
            if (mw) begin
                pcw = 0; ifw = 0; idw = 0; exw = 0;
                pmw[k] = 1;
            end else begin
                pmw[k] = 0;
                if (br) begin
                    fl = 1; bub = 1; rem[k] = 0;
                end else if (rem[k] > 0) begin
                    pcw = 0; ifw = 0; bub = 1; rem[k] = rem[k] - 1;
                end else if (hit) begin
                    pcw = 0; ifw = 0; bub = 1; rem[k] = lu_n[k] - 1;
                end
            end
            if (!pcw && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
        end
        ctl = {pcw, ifw, fl, idw, bub, exw, busy_e};
    endtask

    task automatic drive(input bit rst, input bit mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                         input bit br, input bit req, input bit rdy);
        exp_t e;
        bit   hit, mw;
        @(posedge clk);
        #1;
        reset = rst; id_ex_mem_read = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
        if_id_uses_rt = urt; ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
        hit = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
        mw = req && !rdy;
        e.seq = 16'(seq_n);
        step_model(0, hit, mw, br, rst, e.ctl0, e.cnt0);
        step_model(1, hit, mw, br, rst, e.ctl1, e.cnt1);
        q.push_back(e);
        seq_n++;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total += 4;
            if ({pcw0, ifw0, fl0, idw0, bub0, exw0, busy0} !== e.ctl0) begin
                bad++;
                $display("FAIL ctl_lu1 seq=%0d got=%b want=%b", e.seq,
                         {pcw0, ifw0, fl0, idw0, bub0, exw0, busy0}, e.ctl0);
            end
            if (16'(cnt0) !== e.cnt0) begin
                bad++;
                $display("FAIL cnt_lu1 seq=%0d got=%0d want=%0d", e.seq, cnt0, e.cnt0);
            end
            if ({pcw1, ifw1, fl1, idw1, bub1, exw1, busy1} !== e.ctl1) begin
                bad++;
                $display("FAIL ctl_lu3 seq=%0d got=%b want=%b", e.seq,
                         {pcw1, ifw1, fl1, idw1, bub1, exw1, busy1}, e.ctl1);
            end
            if (16'(cnt1) !== e.cnt1) begin
                bad++;
                $display("FAIL cnt_lu3 seq=%0d got=%0d want=%0d", e.seq, cnt1, e.cnt1);
            end
        end
    end

    initial begin
        lu_n[0] = 1; lu_n[1] = 3;
        cmax[0] = (1 << CW0) - 1; cmax[1] = (1 << CW1) - 1;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; pmw[k] = 0; cnt[k] = 0;
        end
        reset = 1; id_ex_mem_read = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
        if_id_uses_rt = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(2);
        // Single load-use on $5
        drive(0, 1, 5, 5, 0, 0, 0, 0, 0);
        nop(4);
        // $0 destination, rt without uses_rt, rt with uses_rt
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 7, 1, 7, 0, 0, 0, 0);
        drive(0, 1, 7, 1, 7, 1, 0, 0, 0);
        nop(4);
        // Four-cycle memory freeze with a branch inside it
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(2);
        // Branch during second stall cycle
        drive(0, 1, 9, 9, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop(3);
        // Freeze during a multi-cycle stall, then resume it
        drive(0, 1, 3, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(3);
        // Reset mid-stall and mid-freeze
        drive(0, 1, 4, 4, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        nop(1);
        // Counter saturation on both widths
        for (int i = 0; i < (1 << CW0) + 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
